// File: rtl/trng_vn_packer.sv
// Von Neumann debiaser and word packer for a single-bit raw entropy stream, with valid/ready output.
// Optional repetition-count health test enabled by defining TRNG_RCT_EN.
module trng_vn_packer #(
    parameter int WORD_WIDTH = 8,
    parameter int RCT_CUTOFF = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  raw_bit,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow,
    output logic                  rct_fail
);

    localparam int CW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WORD_WIDTH - 1);
    localparam logic WAIT_FIRST  = 1'b0;
    localparam logic WAIT_SECOND = 1'b1;

    if (WORD_WIDTH < 2 || WORD_WIDTH > 64 || RCT_CUTOFF < 2 || RCT_CUTOFF > 1024) begin : g_bad_param
        $error("trng_vn_packer: parameter out of legal range");
    end

    logic                  state_q, state_d;
    logic                  first_q, first_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  vn_valid_s;
    logic                  done_s;
    logic [WORD_WIDTH-1:0] word_s;
    logic                  rct_block_s;

`ifdef TRNG_RCT_EN
    localparam int RW = $clog2(RCT_CUTOFF + 1);
    localparam logic [RW-1:0] RCT_MAX = RW'(RCT_CUTOFF);

    logic [RW-1:0] rct_cnt_q, rct_cnt_d;
    logic          rct_prev_q, rct_prev_d;
    logic          rct_seen_q, rct_seen_d;
    logic          rct_fail_q, rct_fail_d;

    // Repetition-count test on raw samples; a gap in enable restarts the run.
    always_comb begin
        rct_cnt_d  = rct_cnt_q;
        rct_prev_d = rct_prev_q;
        rct_seen_d = rct_seen_q;
        rct_fail_d = rct_fail_q;
        if (enable) begin
            rct_prev_d = raw_bit;
            rct_seen_d = 1'b1;
            if (!rct_seen_q || (raw_bit != rct_prev_q)) begin
                rct_cnt_d = RW'(1);
            end else if (rct_cnt_q != RCT_MAX) begin
                rct_cnt_d = rct_cnt_q + RW'(1);
            end else begin
                rct_cnt_d = rct_cnt_q;
            end
            if (rct_cnt_d == RCT_MAX) begin
                rct_fail_d = 1'b1;
            end else begin
                rct_fail_d = rct_fail_q;
            end
        end else begin
            rct_seen_d = 1'b0;
        end
    end

    // Health-test state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            rct_cnt_q  <= '0;
            rct_prev_q <= 1'b0;
            rct_seen_q <= 1'b0;
            rct_fail_q <= 1'b0;
        end else begin
            rct_cnt_q  <= rct_cnt_d;
            rct_prev_q <= rct_prev_d;
            rct_seen_q <= rct_seen_d;
            rct_fail_q <= rct_fail_d;
        end
    end

    assign rct_block_s = rct_fail_q;
    assign rct_fail    = rct_fail_q;
`else
    assign rct_block_s = 1'b0;
    assign rct_fail    = 1'b0;
`endif

    // Pair FSM, packing and output load/handshake.
    always_comb begin
        state_d    = state_q;
        first_d    = first_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ovf_d      = ovf_q;
        vn_valid_s = 1'b0;
        done_s     = 1'b0;
        word_s     = shift_q;

        if (!enable) begin
            state_d = WAIT_FIRST;
        end else begin
            case (state_q)
                WAIT_FIRST: begin
                    first_d = raw_bit;
                    state_d = WAIT_SECOND;
                end
                WAIT_SECOND: begin
                    vn_valid_s = (raw_bit != first_q);
                    state_d    = WAIT_FIRST;
                end
                default: state_d = WAIT_FIRST;
            endcase
        end

        // Pair "10" yields 1 and "01" yields 0, i.e. the corrected bit equals the first sample.
        word_s[cnt_q] = first_q;
        if (vn_valid_s) begin
            if (cnt_q == LAST_IDX) begin
                cnt_d   = '0;
                shift_d = '0;
                done_s  = 1'b1;
            end else begin
                cnt_d   = cnt_q + CW'(1);
                shift_d = word_s;
            end
        end else begin
            cnt_d = cnt_q;
        end

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        if (done_s && !rct_block_s) begin
            if (!valid_q || out_ready) begin
                data_d  = word_s;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= WAIT_FIRST;
            first_q <= 1'b0;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_trng_vn_packer.sv
// Directed testbench for trng_vn_packer (WORD_WIDTH=8, RCT_CUTOFF=32).
module tb_trng_vn_packer;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       raw_bit;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       overflow;
    logic       rct_fail;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       en;
        logic       raw;
        logic       rdy;
        logic       exp_v;
        logic [7:0] exp_d;
    } vec_t;

    vec_t tv[17];

    trng_vn_packer #(.WORD_WIDTH(8), .RCT_CUTOFF(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .raw_bit   (raw_bit),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .rct_fail  (rct_fail)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic en, input logic rb, input logic rdy);
        enable    = en;
        raw_bit   = rb;
        out_ready = rdy;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int xfers;
        logic exp_rct;

        reset = 1'b1; enable = 1'b0; raw_bit = 1'b0; out_ready = 1'b0;
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        reset = 1'b0;
        chk("reset_data", out_data, 8'h00);
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_ovf", overflow, 1'b0);
        chk("reset_rct", rct_fail, 1'b0);

        // Test 1: pairs 10,01 alternating -> 0x55, valid for exactly one cycle
        for (int i = 0; i < 16; i++) begin
            tv[i].en    = 1'b1;
            tv[i].rdy   = 1'b1;
            tv[i].raw   = (((i / 2) % 2) == 0) ? ((i % 2) == 0) : ((i % 2) == 1);
            tv[i].exp_v = (i == 15);
            tv[i].exp_d = (i == 15) ? 8'h55 : 8'h00;
        end
        tv[16] = '{en: 1'b0, raw: 1'b0, rdy: 1'b1, exp_v: 1'b0, exp_d: 8'h55};
        for (int i = 0; i < 17; i++) begin
            tick(tv[i].en, tv[i].raw, tv[i].rdy);
            chk($sformatf("t1_valid[%0d]", i), out_valid, tv[i].exp_v);
            chk($sformatf("t1_data[%0d]", i), out_data, tv[i].exp_d);
        end

        // Test 2: 00,11 pairs never produce a bit
        for (int i = 0; i < 64; i++) begin
            tick(1'b1, logic'((i / 2) % 2), 1'b1);
            chk($sformatf("t2_valid[%0d]", i), out_valid, 1'b0);
        end
        chk("t2_ovf", overflow, 1'b0);

        // Test 3: backpressure, 24 pairs of 10
        for (int i = 0; i < 48; i++) begin
            tick(1'b1, logic'((i % 2) == 0), 1'b0);
            if (i == 14) chk("t3_valid_early", out_valid, 1'b0);
            if (i == 15) chk("t3_first_word", out_data, 8'hFF);
            if (i == 30) chk("t3_ovf_early", overflow, 1'b0);
            if (i == 31) chk("t3_ovf_set", overflow, 1'b1);
        end
        chk("t3_held_valid", out_valid, 1'b1);
        chk("t3_held_data", out_data, 8'hFF);
        chk("t3_ovf_sticky", overflow, 1'b1);
        xfers = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) xfers++;
            tick(1'b0, 1'b0, 1'b1);
        end
        chk("t3_xfers", xfers, 1);
        chk("t3_valid_after", out_valid, 1'b0);
        chk("t3_data_after", out_data, 8'hFF);

        // Test 4: half pair discarded across an enable gap -> 0x07
        do_reset();
        chk("t4_reset_ovf", overflow, 1'b0);
        chk("t4_reset_data", out_data, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1, 1'b1);
            tick(1'b1, 1'b0, 1'b1);
        end
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (i == 4) chk("t4_valid_before", out_valid, 1'b0);
            tick(1'b1, 1'b1, 1'b1);
        end
        chk("t4_valid", out_valid, 1'b1);
        chk("t4_data", out_data, 8'h07);

        // Test 5: reset abandons a partial word
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            tick(1'b1, 1'b1, 1'b1);
        end
        do_reset();
        chk("t5_reset_valid", out_valid, 1'b0);
        for (int j = 0; j < 16; j++) begin
            tick(1'b1, logic'((j % 2) == 0), 1'b1);
            if (j == 14) chk("t5_valid_early", out_valid, 1'b0);
        end
        chk("t5_valid", out_valid, 1'b1);
        chk("t5_data", out_data, 8'hFF);
        chk("t5_ovf", overflow, 1'b0);

        // Test 6: constant 1 raw stream
        do_reset();
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 1'b1, 1'b1);
`ifdef TRNG_RCT_EN
            exp_rct = (i >= 31);
`else
            exp_rct = 1'b0;
`endif
            chk($sformatf("t6_rct[%0d]", i), rct_fail, exp_rct);
            chk($sformatf("t6_valid[%0d]", i), out_valid, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
